// File: rtl/alu_op_sequencer.sv
// Front-end sequencer for the 8-bit ALU. It takes one request at a time, chains
// 16-bit add/sub over two byte passes, and owns the ALU SREG load port.
module alu_op_sequencer #(
  parameter bit WORD_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic        req_use_carry,
  input  logic        req_word,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic        sreg_wr_en,
  input  logic [7:0]  sreg_wr_data,
  output logic        resp_valid,
  output logic [15:0] resp_result,
  output logic [7:0]  resp_sreg,
  output logic [7:0]  alu_arg1,
  output logic [7:0]  alu_arg2,
  output logic [2:0]  alu_op,
  output logic        alu_use_carry,
  output logic        alu_mem_write,
  output logic [7:0]  alu_mem_data,
  input  logic [15:0] alu_q,
  input  logic [7:0]  alu_sreg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_HI   = 3'd2,
    S_FIX  = 3'd3,
    S_RESP = 3'd4
  } state_t;

  localparam logic [2:0] OP_MUL = 3'd2;

  state_t      state_q, state_d;
  logic [15:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [2:0]  op_q, op_d;
  logic        use_carry_q, use_carry_d;
  logic        word_q, word_d;
  logic        z_lo_q, z_lo_d;
  logic        accept;

  assign accept = (state_q == S_IDLE) && req_valid && !sreg_wr_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
      op_q        <= '0;
      use_carry_q <= 1'b0;
      word_q      <= 1'b0;
      z_lo_q      <= 1'b0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      op_q        <= op_d;
      use_carry_q <= use_carry_d;
      word_q      <= word_d;
      z_lo_q      <= z_lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = word_q ? S_HI : S_RESP;
      S_HI:    state_d = S_FIX;
      S_FIX:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture and result/low-Z collection across the byte passes.
  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    use_carry_d = use_carry_q;
    word_d      = word_q;
    result_d    = result_q;
    z_lo_d      = z_lo_q;
    if (accept) begin
      a_d         = req_a;
      b_d         = req_b;
      op_d        = req_op;
      use_carry_d = req_use_carry;
      word_d      = req_word & WORD_EN & (req_op <= 3'd1);
    end
    if (state_q == S_EXEC) begin
      result_d = (op_q == OP_MUL) ? alu_q : {8'h00, alu_q[7:0]};
    end
    if (state_q == S_HI) begin
      result_d[15:8] = alu_q[7:0];
      z_lo_d         = alu_sreg[1];
    end
  end

  always_comb begin
    req_ready     = 1'b0;
    alu_arg1      = '0;
    alu_arg2      = '0;
    alu_op        = '0;
    alu_use_carry = 1'b0;
    alu_mem_write = 1'b1;
    alu_mem_data  = alu_sreg;
    resp_valid    = 1'b0;
    resp_result   = '0;
    resp_sreg     = '0;
    unique case (state_q)
      S_IDLE: begin
        req_ready    = !sreg_wr_en;
        alu_mem_data = sreg_wr_en ? sreg_wr_data : alu_sreg;
      end
      S_EXEC: begin
        alu_arg1      = a_q[7:0];
        alu_arg2      = b_q[7:0];
        alu_op        = op_q;
        alu_use_carry = word_q ? 1'b0 : use_carry_q;
        alu_mem_write = 1'b0;
      end
      S_HI: begin
        alu_arg1      = a_q[15:8];
        alu_arg2      = b_q[15:8];
        alu_op        = op_q;
        alu_use_carry = 1'b1;
        alu_mem_write = 1'b0;
      end
      // Word Z is only set when both byte passes produced zero.
      S_FIX: begin
        alu_mem_data = {alu_sreg[7:2], alu_sreg[1] & z_lo_q, alu_sreg[0]};
      end
      S_RESP: begin
        resp_valid  = 1'b1;
        resp_result = result_q;
        resp_sreg   = alu_sreg;
      end
      default: begin
        alu_mem_data = alu_sreg;
      end
    endcase
  end

endmodule
